// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: CPU and loader req/ack ports plus the
// shared memory port. The arbiter uses the slave view; requesters/memory the master view.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;

    logic          ldr_req;
    logic          ldr_we;
    logic [AW-1:0] ldr_addr;
    logic [DW-1:0] ldr_wdata;
    logic [DW-1:0] ldr_rdata;
    logic          ldr_ack;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          grant;
    logic          busy;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
        input  mem_rdata,
        output cpu_rdata, cpu_ack, ldr_rdata, ldr_ack,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output grant, busy
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output ldr_req, ldr_we, ldr_addr, ldr_wdata,
        output mem_rdata,
        input  cpu_rdata, cpu_ack, ldr_rdata, ldr_ack,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  grant, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single memory port of the multi-cycle MIPS32.
// One transaction at a time: IDLE -> ISSUE -> (WAIT x MEM_LAT for reads) -> RESP.
// All outputs are registered; read data is held per requester until its next read.
module mem_port_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MEM_LAT  = 1,
    parameter int PRIO_CPU = 0
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t        r_state;
    logic          r_last;
    logic          r_grant;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_cpu_rdata;
    logic [DW-1:0] r_ldr_rdata;
    logic          r_cpu_ack;
    logic          r_ldr_ack;
    logic          r_mem_en;
    logic          r_mem_we;
    logic          r_busy;
    logic [2:0]    r_cnt;

    logic          w_any_req;
    logic          w_pick_ldr;

    // Arbitration decision: single requester wins outright; conflicts go by priority mode
    always_comb begin
        w_any_req  = bus.cpu_req | bus.ldr_req;
        w_pick_ldr = 1'b0;
        if (bus.cpu_req && bus.ldr_req) begin
            w_pick_ldr = (PRIO_CPU != 0) ? 1'b0 : ~r_last;
        end else begin
            w_pick_ldr = bus.ldr_req;
        end
    end

    // Transaction sequencer with registered memory-port, ack and read-data outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_last      <= 1'b1;
            r_grant     <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cpu_rdata <= '0;
            r_ldr_rdata <= '0;
            r_cpu_ack   <= 1'b0;
            r_ldr_ack   <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_busy      <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_cpu_ack <= 1'b0;
            r_ldr_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_grant  <= w_pick_ldr;
                        r_last   <= w_pick_ldr;
                        r_we     <= w_pick_ldr ? bus.ldr_we    : bus.cpu_we;
                        r_addr   <= w_pick_ldr ? bus.ldr_addr  : bus.cpu_addr;
                        r_wdata  <= w_pick_ldr ? bus.ldr_wdata : bus.cpu_wdata;
                        r_mem_en <= 1'b1;
                        r_mem_we <= w_pick_ldr ? bus.ldr_we    : bus.cpu_we;
                        r_busy   <= 1'b1;
                        r_state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_mem_en <= 1'b0;
                    r_mem_we <= 1'b0;
                    if (r_we) begin
                        // Ack is registered, so it is raised on the edge entering RESP
                        r_cpu_ack <= ~r_grant;
                        r_ldr_ack <= r_grant;
                        r_state   <= S_RESP;
                    end else begin
                        r_cnt   <= 3'(MEM_LAT);
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 3'd1;
                    if (r_cnt == 3'd1) begin
                        if (r_grant) begin
                            r_ldr_rdata <= bus.mem_rdata;
                        end else begin
                            r_cpu_rdata <= bus.mem_rdata;
                        end
                        r_cpu_ack <= ~r_grant;
                        r_ldr_ack <= r_grant;
                        r_state   <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.cpu_rdata = r_cpu_rdata;
    assign bus.ldr_rdata = r_ldr_rdata;
    assign bus.cpu_ack   = r_cpu_ack;
    assign bus.ldr_ack   = r_ldr_ack;
    assign bus.grant     = r_grant;
    assign bus.busy      = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (round-robin and CPU-priority) share
// one set of requester inputs; each has its own latency-accurate memory model.
module tb_mem_port_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic        ldr_req = 1'b0, ldr_we = 1'b0;
    logic [31:0] ldr_addr = '0, ldr_wdata = '0;

    logic        d_mem_en [2];
    logic        d_mem_we [2];
    logic [31:0] d_mem_addr [2];
    logic [31:0] d_mem_wdata [2];
    logic [31:0] d_cpu_rdata [2];
    logic [31:0] d_ldr_rdata [2];
    logic        d_cpu_ack [2];
    logic        d_ldr_ack [2];
    logic        d_grant [2];
    logic        d_busy [2];

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    // Memory contents as a pure function of address
    function automatic logic [31:0] mem_f(input logic [31:0] a);
        if (a == 32'h40) return 32'hDEADBEEF;
        return (a * 32'h9E3779B9) ^ 32'h5A5A5A5A;
    endfunction

    // Instance g uses PRIO_CPU=g
    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();
        logic [LAT-1:0] rv;
        logic [31:0]    ra [LAT];

        mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT), .PRIO_CPU(g)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        assign bus.cpu_req   = cpu_req;
        assign bus.cpu_we    = cpu_we;
        assign bus.cpu_addr  = cpu_addr;
        assign bus.cpu_wdata = cpu_wdata;
        assign bus.ldr_req   = ldr_req;
        assign bus.ldr_we    = ldr_we;
        assign bus.ldr_addr  = ldr_addr;
        assign bus.ldr_wdata = ldr_wdata;

        // Read data is valid only exactly LAT cycles after the read strobe
        always @(posedge clk) begin
            rv[0] <= bus.mem_en & ~bus.mem_we;
            ra[0] <= bus.mem_addr;
            for (int i = 1; i < LAT; i++) begin
                rv[i] <= rv[i-1];
                ra[i] <= ra[i-1];
            end
        end
        assign bus.mem_rdata = rv[LAT-1] ? mem_f(ra[LAT-1]) : 32'hBAD0BAD0;

        assign d_mem_en[g]    = bus.mem_en;
        assign d_mem_we[g]    = bus.mem_we;
        assign d_mem_addr[g]  = bus.mem_addr;
        assign d_mem_wdata[g] = bus.mem_wdata;
        assign d_cpu_rdata[g] = bus.cpu_rdata;
        assign d_ldr_rdata[g] = bus.ldr_rdata;
        assign d_cpu_ack[g]   = bus.cpu_ack;
        assign d_ldr_ack[g]   = bus.ldr_ack;
        assign d_grant[g]     = bus.grant;
        assign d_busy[g]      = bus.busy;
    end

    // Transaction-level reference: each grant schedules its issue/ack cycles
    int          cyc = 0;
    int          m_issue [2];
    int          m_ack [2];
    int          m_free [2];
    logic        m_last [2];
    logic        m_grant [2];
    logic        m_we [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_wdata [2];
    logic [31:0] m_rd [2][2];

    task automatic model_step();
        logic win;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_issue[k] = -1; m_ack[k] = -1; m_free[k] = cyc + 1;
                m_last[k] = 1'b1; m_grant[k] = 1'b0; m_we[k] = 1'b0;
                m_addr[k] = '0; m_wdata[k] = '0; m_rd[k][0] = '0; m_rd[k][1] = '0;
            end else begin
                if (cyc + 1 == m_ack[k] && !m_we[k]) m_rd[k][m_grant[k]] = mem_f(m_addr[k]);
                if (cyc >= m_free[k] && (cpu_req || ldr_req)) begin
                    if (cpu_req && ldr_req) win = (k == 1) ? 1'b0 : ~m_last[k];
                    else win = ldr_req;
                    m_grant[k] = win; m_last[k] = win;
                    m_we[k]    = win ? ldr_we : cpu_we;
                    m_addr[k]  = win ? ldr_addr : cpu_addr;
                    m_wdata[k] = win ? ldr_wdata : cpu_wdata;
                    m_issue[k] = cyc + 1;
                    m_ack[k]   = cyc + 2 + (m_we[k] ? 0 : LAT);
                    m_free[k]  = m_ack[k] + 1;
                end
            end
        end
        cyc++;
    endtask

    // Advance to the middle of the next cycle and update the reference
    task automatic tick();
        @(negedge clk);
        model_step();
    endtask

    task automatic drain();
        rst = 1'b0; cpu_req = 1'b0; ldr_req = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h80; cpu_wdata = 32'h0;
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 32'h200; ldr_wdata = 32'hCAFE0001;
        for (int c = 0; c < 2; c++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                n_total++; if (d_mem_en[k] !== 1'b0) $display("FAIL rst_mem_en[%0d] got %0b exp 0", k, d_mem_en[k]); else n_pass++;
                n_total++; if (d_busy[k] !== 1'b0) $display("FAIL rst_busy[%0d] got %0b exp 0", k, d_busy[k]); else n_pass++;
                n_total++; if ({d_cpu_ack[k], d_ldr_ack[k]} !== 2'b00) $display("FAIL rst_acks[%0d] got %b exp 00", k, {d_cpu_ack[k], d_ldr_ack[k]}); else n_pass++;
                n_total++; if ({d_cpu_rdata[k], d_ldr_rdata[k]} !== 64'h0) $display("FAIL rst_rdata[%0d] got %h exp 0", k, {d_cpu_rdata[k], d_ldr_rdata[k]}); else n_pass++;
            end
        end
        rst = 1'b0;
        tick();
        for (int k = 0; k < 2; k++) begin
            n_total++; if (d_mem_en[k] !== 1'b1) $display("FAIL first_issue_en[%0d] got %0b exp 1", k, d_mem_en[k]); else n_pass++;
            n_total++; if (d_grant[k] !== 1'b0) $display("FAIL first_grant[%0d] got %0b exp 0", k, d_grant[k]); else n_pass++;
            n_total++; if (d_mem_addr[k] !== 32'h80) $display("FAIL first_addr[%0d] got %h exp 00000080", k, d_mem_addr[k]); else n_pass++;
        end
        cpu_req = 1'b0; ldr_req = 1'b0;
    endtask

    task automatic test_cpu_read();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40; cpu_wdata = $urandom;
        for (int i = 1; i <= LAT + 3; i++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                n_total++; if (d_mem_en[k] !== (i == 1)) $display("FAIL rd_mem_en[%0d] T+%0d got %0b exp %0b", k, i, d_mem_en[k], (i == 1)); else n_pass++;
                n_total++; if (d_cpu_ack[k] !== (i == 2 + LAT)) $display("FAIL rd_cpu_ack[%0d] T+%0d got %0b exp %0b", k, i, d_cpu_ack[k], (i == 2 + LAT)); else n_pass++;
                n_total++; if (d_ldr_rdata[k] !== 32'h0) $display("FAIL rd_ldr_rdata[%0d] T+%0d got %h exp 0", k, i, d_ldr_rdata[k]); else n_pass++;
                if (i == 1) begin
                    n_total++; if (d_mem_addr[k] !== 32'h40 || d_mem_we[k] !== 1'b0) $display("FAIL rd_issue[%0d] got addr %h we %0b exp 00000040/0", k, d_mem_addr[k], d_mem_we[k]); else n_pass++;
                end
                if (i == 2 + LAT) begin
                    n_total++; if (d_cpu_rdata[k] !== 32'hDEADBEEF) $display("FAIL rd_cpu_rdata[%0d] got %h exp deadbeef", k, d_cpu_rdata[k]); else n_pass++;
                end
            end
            if (i == 2 + LAT) cpu_req = 1'b0;
        end
    endtask

    task automatic test_ldr_write();
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 32'h100; ldr_wdata = 32'h12345678;
        for (int i = 1; i <= 3; i++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                n_total++; if (d_mem_en[k] !== (i == 1)) $display("FAIL wr_mem_en[%0d] T+%0d got %0b exp %0b", k, i, d_mem_en[k], (i == 1)); else n_pass++;
                n_total++; if (d_ldr_ack[k] !== (i == 2) || d_cpu_ack[k] !== 1'b0) $display("FAIL wr_acks[%0d] T+%0d got cpu %0b ldr %0b exp 0/%0b", k, i, d_cpu_ack[k], d_ldr_ack[k], (i == 2)); else n_pass++;
                n_total++; if (d_cpu_rdata[k] !== 32'hDEADBEEF || d_ldr_rdata[k] !== 32'h0) $display("FAIL wr_rdata_hold[%0d] T+%0d got %h/%h exp deadbeef/0", k, i, d_cpu_rdata[k], d_ldr_rdata[k]); else n_pass++;
                n_total++; if (d_grant[k] !== 1'b1) $display("FAIL wr_grant[%0d] T+%0d got %0b exp 1", k, i, d_grant[k]); else n_pass++;
                if (i == 1) begin
                    n_total++; if (d_mem_we[k] !== 1'b1 || d_mem_addr[k] !== 32'h100 || d_mem_wdata[k] !== 32'h12345678) $display("FAIL wr_issue[%0d] got we %0b addr %h data %h exp 1/00000100/12345678", k, d_mem_we[k], d_mem_addr[k], d_mem_wdata[k]); else n_pass++;
                end
            end
            if (i == 2) ldr_req = 1'b0;
        end
    endtask

    task automatic test_conflict();
        logic ec, el, eo, ee;
        int   n;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hAAAA0001;
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 32'h20; ldr_wdata = 32'hBBBB0002;
        for (int i = 1; i <= 15; i++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                ec = 1'b0; el = 1'b0; ee = 1'b0; eo = 1'b0;
                if (i >= 2 && i <= 11 && (i - 2) % 3 == 0) begin
                    n = (i - 2) / 3;
                    if (k == 1 || n % 2 == 0) ec = 1'b1; else el = 1'b1;
                end
                if (i == 14) el = 1'b1;
                if (i >= 1 && i <= 10 && (i - 1) % 3 == 0) begin
                    n = (i - 1) / 3;
                    ee = 1'b1; eo = (k == 1) ? 1'b0 : 1'(n % 2);
                end
                if (i == 13) begin ee = 1'b1; eo = 1'b1; end
                n_total++; if (d_cpu_ack[k] !== ec) $display("FAIL cf_cpu_ack[%0d] T+%0d got %0b exp %0b", k, i, d_cpu_ack[k], ec); else n_pass++;
                n_total++; if (d_ldr_ack[k] !== el) $display("FAIL cf_ldr_ack[%0d] T+%0d got %0b exp %0b", k, i, d_ldr_ack[k], el); else n_pass++;
                n_total++; if ((d_cpu_ack[k] & d_ldr_ack[k]) !== 1'b0) $display("FAIL cf_overlap[%0d] T+%0d got 1 exp 0", k, i); else n_pass++;
                n_total++; if (d_mem_en[k] !== ee) $display("FAIL cf_mem_en[%0d] T+%0d got %0b exp %0b", k, i, d_mem_en[k], ee); else n_pass++;
                if (ee) begin
                    n_total++; if (d_mem_addr[k] !== (eo ? 32'h20 : 32'h10)) $display("FAIL cf_owner_addr[%0d] T+%0d got %h exp %h", k, i, d_mem_addr[k], (eo ? 32'h20 : 32'h10)); else n_pass++;
                end
            end
            if (i == 11) cpu_req = 1'b0;
            if (i == 14) ldr_req = 1'b0;
        end
    endtask

    task automatic test_abort();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h44;
        tick();
        tick();
        for (int k = 0; k < 2; k++) begin
            n_total++; if (d_busy[k] !== 1'b1) $display("FAIL ab_busy_wait[%0d] got %0b exp 1", k, d_busy[k]); else n_pass++;
        end
        rst = 1'b1; cpu_req = 1'b0;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_total++; if (d_busy[k] !== 1'b0 || d_mem_en[k] !== 1'b0) $display("FAIL ab_idle[%0d] got busy %0b en %0b exp 0/0", k, d_busy[k], d_mem_en[k]); else n_pass++;
            n_total++; if (d_cpu_rdata[k] !== 32'h0 || d_grant[k] !== 1'b0) $display("FAIL ab_regs[%0d] got rdata %h grant %0b exp 0/0", k, d_cpu_rdata[k], d_grant[k]); else n_pass++;
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                n_total++; if (d_cpu_ack[k] !== 1'b0 || d_busy[k] !== 1'b0) $display("FAIL ab_no_ack[%0d] +%0d got ack %0b busy %0b exp 0/0", k, i, d_cpu_ack[k], d_busy[k]); else n_pass++;
            end
        end
    endtask

    task automatic test_drop();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h48;
        for (int i = 1; i <= LAT + 3; i++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                n_total++; if (d_cpu_ack[k] !== (i == 2 + LAT)) $display("FAIL dr_cpu_ack[%0d] T+%0d got %0b exp %0b", k, i, d_cpu_ack[k], (i == 2 + LAT)); else n_pass++;
                if (i == 2 + LAT) begin
                    n_total++; if (d_cpu_rdata[k] !== mem_f(32'h48)) $display("FAIL dr_cpu_rdata[%0d] got %h exp %h", k, d_cpu_rdata[k], mem_f(32'h48)); else n_pass++;
                end
            end
            if (i == 1) cpu_req = 1'b0;
        end
    endtask

    task automatic test_random();
        logic ee, ec, el, eb;
        for (int c = 0; c < 600; c++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                ee = (cyc == m_issue[k]);
                ec = (cyc == m_ack[k]) && !m_grant[k];
                el = (cyc == m_ack[k]) && m_grant[k];
                eb = (m_issue[k] >= 0) && (cyc >= m_issue[k]) && (cyc < m_free[k]);
                n_total++; if (d_mem_en[k] !== ee || d_mem_we[k] !== (ee & m_we[k])) $display("FAIL rnd_en_we[%0d] c=%0d got %0b%0b exp %0b%0b", k, c, d_mem_en[k], d_mem_we[k], ee, ee & m_we[k]); else n_pass++;
                n_total++; if (d_mem_addr[k] !== m_addr[k] || d_mem_wdata[k] !== m_wdata[k]) $display("FAIL rnd_addr_data[%0d] c=%0d got %h/%h exp %h/%h", k, c, d_mem_addr[k], d_mem_wdata[k], m_addr[k], m_wdata[k]); else n_pass++;
                n_total++; if (d_cpu_ack[k] !== ec || d_ldr_ack[k] !== el) $display("FAIL rnd_acks[%0d] c=%0d got %0b%0b exp %0b%0b", k, c, d_cpu_ack[k], d_ldr_ack[k], ec, el); else n_pass++;
                n_total++; if (d_cpu_rdata[k] !== m_rd[k][0] || d_ldr_rdata[k] !== m_rd[k][1]) $display("FAIL rnd_rdata[%0d] c=%0d got %h/%h exp %h/%h", k, c, d_cpu_rdata[k], d_ldr_rdata[k], m_rd[k][0], m_rd[k][1]); else n_pass++;
                n_total++; if (d_grant[k] !== m_grant[k] || d_busy[k] !== eb) $display("FAIL rnd_grant_busy[%0d] c=%0d got %0b%0b exp %0b%0b", k, c, d_grant[k], d_busy[k], m_grant[k], eb); else n_pass++;
            end
            rst = ($urandom_range(99, 0) == 0);
            if (cpu_req) begin
                if (d_cpu_ack[0]) begin
                    if ($urandom_range(1, 0) == 1) begin
                        cpu_we = 1'($urandom_range(1, 0)); cpu_addr = $urandom & 32'hFFC; cpu_wdata = $urandom;
                    end else cpu_req = 1'b0;
                end else if ($urandom_range(19, 0) == 0) cpu_req = 1'b0;
            end else if ($urandom_range(2, 0) == 0) begin
                cpu_req = 1'b1; cpu_we = 1'($urandom_range(1, 0)); cpu_addr = $urandom & 32'hFFC; cpu_wdata = $urandom;
            end
            if (ldr_req) begin
                if (d_ldr_ack[0]) begin
                    if ($urandom_range(1, 0) == 1) begin
                        ldr_we = 1'($urandom_range(1, 0)); ldr_addr = $urandom & 32'hFFC; ldr_wdata = $urandom;
                    end else ldr_req = 1'b0;
                end else if ($urandom_range(19, 0) == 0) ldr_req = 1'b0;
            end else if ($urandom_range(2, 0) == 0) begin
                ldr_req = 1'b1; ldr_we = 1'($urandom_range(1, 0)); ldr_addr = $urandom & 32'hFFC; ldr_wdata = $urandom;
            end
        end
    endtask

    initial begin
        test_reset();
        drain();
        test_cpu_read();
        drain();
        test_ldr_write();
        drain();
        test_conflict();
        drain();
        test_abort();
        drain();
        test_drop();
        drain();
        test_random();
        drain();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end

endmodule
